// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_param
// Description : Parametrised single-clock FIFO with registered, lag-free
//               full/empty/level flags, programmable almost-full/almost-empty
//               thresholds, sticky overflow/underflow flags, synchronous
//               flush and read+write while full.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int AF_THRESH = (1 << ADDR_W) - 4,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int              c_depth_int = 1 << ADDR_W;
    localparam logic [ADDR_W:0] c_af_thresh = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] c_ae_thresh = (ADDR_W + 1)'(AE_THRESH);

    // Storage array (not reset)
    logic [DATA_W-1:0] r_mem [0:c_depth_int-1];

    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_overflow;
    logic              r_underflow;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_rd_acc;
    logic              w_wr_acc;
    logic [ADDR_W:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_level_nxt;
    logic              w_full_nxt;
    logic              w_empty_nxt;

    // Accept decisions and post-edge pointer/flag values; flags are computed
    // from the next pointers so they register without a cycle of lag.
    always_comb begin
        w_rd_acc     = rd_en && !r_empty;
        // A read in the same cycle frees a slot, so a write to a full FIFO
        // is still accepted.
        w_wr_acc     = wr_en && (!r_full || w_rd_acc);
        w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_acc};
        w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_rd_acc};
        if (clr) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end
        w_level_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_empty_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt);
        w_full_nxt   = (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]) &&
                       (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]);
    end

    // Storage write port; requests are ignored during a flush.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !clr) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Pointers, level, flags and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_level        <= w_level_nxt;
            r_full         <= w_full_nxt;
            r_empty        <= w_empty_nxt;
            r_almost_full  <= (w_level_nxt >= c_af_thresh);
            r_almost_empty <= (w_level_nxt <= c_ae_thresh);
            if (clr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
                r_rd_valid  <= 1'b0;
            end else begin
                r_overflow  <= r_overflow  | (wr_en && !w_wr_acc);
                r_underflow <= r_underflow | (rd_en && !w_rd_acc);
                r_rd_valid  <= w_rd_acc;
                if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
                end
            end
        end
    end

    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_param
// Description : Self-checking bench for sync_fifo_param (ADDR_W=4, AF=12,
//               AE=4) against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int AF    = 12;
    localparam int AE    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_rd_data;
    logic          m_rd_valid;
    logic          m_ovf;
    logic          m_unf;

    sync_fifo_param #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .AF_THRESH(AF),
        .AE_THRESH(AE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .level       (level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
    endtask

    // Drive one cycle of requests, advance the model by the FIFO rules, and
    // return at posedge+1 with inputs idle.
    task automatic cycle(input logic w, input logic [DW-1:0] wd, input logic r, input logic c);
        bit racc;
        bit wacc;
        wr_en = w; wr_data = wd; rd_en = r; clr = c;
        @(posedge clk);
        if (c) begin
            m_q.delete();
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_rd_valid = 1'b0;
        end else begin
            racc = r && (m_q.size() > 0);
            wacc = w && ((m_q.size() < DEPTH) || racc);
            if (racc) m_rd_data = m_q.pop_front();
            m_rd_valid = racc;
            if (wacc) m_q.push_back(wd);
            if (w && !wacc) m_ovf = 1'b1;
            if (r && !racc) m_unf = 1'b1;
        end
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %0b want 1", almost_empty); end
        checks++; if (full !== 1'b0)         begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL reset_almost_full got %0b want 0", almost_full); end
        checks++; if (level !== 5'd0)        begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (rd_data !== 32'h0)     begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
        checks++; if (rd_valid !== 1'b0)     begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err_flags got %b want 00", {overflow, underflow}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0);
            checks++;
            if (level !== 5'(i + 1) || almost_full !== (i + 1 >= AF) || full !== (i + 1 == DEPTH) ||
                almost_empty !== (i + 1 <= AE) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_step%0d got lvl=%0d af=%0b f=%0b ae=%0b e=%0b want lvl=%0d af=%0b f=%0b ae=%0b e=0",
                         i, level, almost_full, full, almost_empty, empty,
                         i + 1, (i + 1 >= AF), (i + 1 == DEPTH), (i + 1 <= AE));
            end
        end
        cycle(1'b1, 32'hDEAD, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %0b want 1", overflow); end
        checks++; if (level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL overflow_level got lvl=%0d f=%0b want 16/1", level, full); end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] last;
        cycle(1'b1, 32'hAA, 1'b1, 1'b0);
        checks++; if (level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_rw_level got lvl=%0d f=%0b want 16/1", level, full); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin errors++; $display("FAIL full_rw_data got v=%0b d=%h want 1/00000000", rd_valid, rd_data); end
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== m_rd_data) begin
                errors++; $display("FAIL drain%0d got v=%0b d=%h want 1/%h", i, rd_valid, rd_data, m_rd_data);
            end
            last = rd_data;
        end
        checks++; if (last !== 32'hAA) begin errors++; $display("FAIL full_rw_last got %h want 000000aa", last); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %0b want 1", empty); end
    endtask

    task automatic test_wrap();
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(32'h50 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== DW'(32'h100 + i)) begin
                errors++; $display("FAIL wrap_read%0d got v=%0b d=%h want 1/%h", i, rd_valid, rd_data, 32'h100 + i);
            end
        end
        checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin errors++; $display("FAIL wrap_end got e=%0b unf=%0b want 1/0", empty, underflow); end
    endtask

    task automatic test_empty_rw();
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (underflow !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("FAIL empty_read got unf=%0b v=%0b want 1/0", underflow, rd_valid); end
        cycle(1'b1, 32'h55, 1'b1, 1'b0);
        checks++; if (level !== 5'd1 || rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rw got lvl=%0d v=%0b want 1/0", level, rd_valid); end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h55) begin errors++; $display("FAIL empty_rw_read got v=%0b d=%h want 1/00000055", rd_valid, rd_data); end
    endtask

    // Bring the FIFO to level 7 with overflow set.
    task automatic build_l7_ovf();
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_clr();
        logic [DW-1:0] held;
        build_l7_ovf();
        checks++; if (level !== 5'd7 || overflow !== 1'b1) begin errors++; $display("FAIL clr_setup got lvl=%0d ovf=%0b want 7/1", level, overflow); end
        held = m_rd_data;
        cycle(1'b1, 32'h77, 1'b1, 1'b1);
        checks++; if (level !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL clr_state got lvl=%0d e=%0b ovf=%0b v=%0b want 0/1/0/0", level, empty, overflow, rd_valid); end
        checks++; if (rd_data !== held) begin errors++; $display("FAIL clr_rd_data_hold got %h want %h", rd_data, held); end
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++; if (level !== 5'd0 || underflow !== 1'b0) begin errors++; $display("FAIL clr_discard got lvl=%0d unf=%0b want 0/0", level, underflow); end

        // Asynchronous reset in the middle of a write burst
        build_l7_ovf();
        wr_en = 1'b1; wr_data = 32'h99;
        #2 rst = 1'b1;
        #1;
        checks++; if (level !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0 ||
                      almost_full !== 1'b0 || overflow !== 1'b0 || rd_data !== 32'h0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst got lvl=%0d e=%0b ae=%0b f=%0b af=%0b ovf=%0b d=%h v=%0b want 0/1/1/0/0/0/0/0",
                               level, empty, almost_empty, full, almost_full, overflow, rd_data, rd_valid); end
        wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b1, 32'h31, 1'b0, 1'b0);
        checks++; if (level !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL post_rst_write got lvl=%0d e=%0b want 1/0", level, empty); end
    endtask

    task automatic test_random();
        logic [4:0] lv;
        logic       w, r, c;
        for (int n = 0; n < 600; n++) begin
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 63) == 0);
            cycle(w, $urandom, r, c);
            lv = 5'(m_q.size());
            checks++;
            if ({full, empty, almost_full, almost_empty, overflow, underflow, level} !==
                {lv == 5'd16, lv == 5'd0, lv >= 5'(AF), lv <= 5'(AE), m_ovf, m_unf, lv}) begin
                errors++;
                $display("FAIL rand_flags%0d got f=%0b e=%0b af=%0b ae=%0b ovf=%0b unf=%0b lvl=%0d want lvl=%0d ovf=%0b unf=%0b",
                         n, full, empty, almost_full, almost_empty, overflow, underflow, level, lv, m_ovf, m_unf);
            end
            checks++;
            if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin
                errors++; $display("FAIL rand_read%0d got v=%0b d=%h want v=%0b d=%h", n, rd_valid, rd_data, m_rd_valid, m_rd_data);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_full_rw();
        test_wrap();
        test_empty_rw();
        test_clr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
